strip_receiver: RTL



---
 rtl/strip_receiver_if.sv | 21 ++
 rtl/strip_receiver.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/strip_receiver_if.sv
// Port bundle for strip_receiver: serial LED input plus the decoded-byte write port and
// the frame status outputs.
interface strip_receiver_if;
  logic        strip_in;
  logic [12:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        frame_done;
  logic [12:0] frame_bytes;
  logic        err;

  modport master (
    input  strip_in,
    output mem_addr, mem_data, mem_we, frame_done, frame_bytes, err
  );

  modport slave (
    output strip_in,
    input  mem_addr, mem_data, mem_we, frame_done, frame_bytes, err
  );
endinterface

// File: rtl/strip_receiver.sv
// Decodes a WS2812-style single-wire bitstream into bytes by high-pulse width and writes
// them to a byte-wide frame memory; a long low gap latches (terminates) the frame.
module strip_receiver #(
  parameter int INPUT_CLOCK_FREQ = 50000000,
  parameter int MAX_LEDS         = 5
) (
  input logic              clk,
  input logic              rst,
  strip_receiver_if.master bus
);
  localparam int THRESH_CYC   = INPUT_CLOCK_FREQ * 3 / 5000000;
  localparam int MAX_HIGH_CYC = INPUT_CLOCK_FREQ / 500000;
  localparam int LATCH_CYC    = INPUT_CLOCK_FREQ / 20000;
  localparam int CNT_W        = $clog2(LATCH_CYC) + 1;

  localparam logic [CNT_W-1:0] THRESH_C     = CNT_W'(THRESH_CYC);
  localparam logic [CNT_W-1:0] HIGH_LAST_C  = CNT_W'(MAX_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LATCH_C      = CNT_W'(LATCH_CYC);
  localparam logic [CNT_W-1:0] LATCH_LAST_C = CNT_W'(LATCH_CYC - 1);
  localparam logic [12:0]      CAP_C        = 13'(MAX_LEDS * 3);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    READY = 2'd1,
    HIGH  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [12:0]      index_q, index_d;
  logic [12:0]      mem_addr_q, mem_addr_d;
  logic [7:0]       mem_data_q, mem_data_d;
  logic             mem_we_q, mem_we_d;
  logic             frame_done_q, frame_done_d;
  logic [12:0]      frame_bytes_q, frame_bytes_d;
  logic             err_q, err_d;

  logic       rise, fall, latch_hit, bit_val;
  logic [7:0] next_byte;

  always_comb begin
    sync1_d       = bus.strip_in;
    sync2_d       = sync1_q;
    prev_d        = sync2_q;
    state_d       = state_q;
    high_cnt_d    = high_cnt_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    index_d       = index_q;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    mem_we_d      = 1'b0;
    frame_done_d  = 1'b0;
    frame_bytes_d = frame_bytes_q;
    err_d         = err_q;

    rise      = sync2_q & ~prev_q;
    fall      = ~sync2_q & prev_q;
    bit_val   = (high_cnt_q >= THRESH_C);
    next_byte = {shift_q[6:0], bit_val};

    // Low counter tracks the current low run and saturates so a latch fires only once.
    if (sync2_q)
      low_cnt_d = '0;
    else if (low_cnt_q == LATCH_C)
      low_cnt_d = low_cnt_q;
    else
      low_cnt_d = low_cnt_q + 1'b1;
    latch_hit = ~sync2_q && (low_cnt_q == LATCH_LAST_C);

    // Index advances the cycle after the write strobe it addressed.
    if (mem_we_q)
      index_d = index_q + 13'd1;

    case (state_q)
      SYNC: begin
        index_d    = '0;
        mem_addr_d = '0;
        bit_cnt_d  = '0;
        shift_d    = '0;
        if (latch_hit) begin
          state_d = READY;
          err_d   = 1'b0;
        end
      end
      READY: begin
        if (rise) begin
          high_cnt_d = '0;
          state_d    = HIGH;
        end else if (latch_hit) begin
          if (index_q != 13'd0) begin
            frame_done_d  = 1'b1;
            frame_bytes_d = index_q;
          end
          bit_cnt_d  = '0;
          shift_d    = '0;
          index_d    = '0;
          mem_addr_d = '0;
          err_d      = 1'b0;
        end
      end
      HIGH: begin
        if (fall) begin
          shift_d   = next_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = READY;
          // Bytes past capacity are still shifted in but never written.
          if (bit_cnt_q == 3'd7 && index_q < CAP_C) begin
            mem_we_d   = 1'b1;
            mem_data_d = next_byte;
            mem_addr_d = index_q;
          end
        end else if (high_cnt_q == HIGH_LAST_C) begin
          err_d     = 1'b1;
          shift_d   = '0;
          bit_cnt_d = '0;
          state_d   = SYNC;
        end else begin
          high_cnt_d = high_cnt_q + 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SYNC;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      prev_q        <= 1'b0;
      low_cnt_q     <= '0;
      high_cnt_q    <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      index_q       <= '0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      mem_we_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_bytes_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      low_cnt_q     <= low_cnt_d;
      high_cnt_q    <= high_cnt_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      index_q       <= index_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      mem_we_q      <= mem_we_d;
      frame_done_q  <= frame_done_d;
      frame_bytes_q <= frame_bytes_d;
      err_q         <= err_d;
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data    = mem_data_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_bytes = frame_bytes_q;
  assign bus.err         = err_q;
endmodule
